// File: rtl/frame_ram_pkg.sv
// Shared types and helpers for the ping-pong frame capture buffer.
// Holds the writer state encoding, default geometry and the address bit-reversal helper.
package frame_ram_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } wr_state_t;

   // Reverses the low aw bits of addr; bits above aw come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] addr, input int aw);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < aw; i++) begin
         r[i] = addr[aw-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_ram_bank.sv
// One bank of the ping-pong buffer: DEPTH x 2*WIDTH storage with a synchronous write
// port and a registered read port whose output register is cleared by reset.
module frame_ram_bank
   import frame_ram_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [2*WIDTH-1:0] wdata,
   input  logic               re,
   input  logic [AW-1:0]      raddr,
   output logic [2*WIDTH-1:0] rdata
);

   logic [2*WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it can map onto RAM; only the read register is reset.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/frame_ram.sv
// Ping-pong capture buffer for complex samples: the writer fills one bank while the reader
// addresses the other. Define FRAME_RAM_BITREV_EN to bit-reverse the read address.
module frame_ram
   import frame_ram_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             ED,
   input  logic [WIDTH-1:0] DReal,
   input  logic [WIDTH-1:0] DImag,
   input  logic             RD_EN,
   input  logic [AW-1:0]    ADDR,
   input  logic             RD_DONE,
   output logic [WIDTH-1:0] DOReal,
   output logic [WIDTH-1:0] DOImag,
   output logic             DOVAL,
   output logic             FRAME_RDY,
   output logic             VALID,
   output logic             OVF,
   output logic             BUSY
);

   wr_state_t          state, state_nx;
   logic [AW:0]        ct;
   logic               wbank;
   logic               rd_sel;
   logic               do_write, last_write;
   logic               we0, we1, re0, re1;
   logic [AW-1:0]      rd_addr;
   logic [2*WIDTH-1:0] rdata0, rdata1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // START restarts the frame from any state, so it outranks frame completion.
   always_comb begin
      state_nx = state;
      if (START) begin
         state_nx = FILL;
      end else if (last_write) begin
         state_nx = IDLE;
      end
   end

   always_comb begin
      do_write   = (state == FILL) && ED && !START;
      last_write = do_write && (ct == (AW+1)'(DEPTH-1));
      we0        = do_write && !wbank;
      we1        = do_write && wbank;
      re0        = RD_EN && wbank;
      re1        = RD_EN && !wbank;
   end

   // rd_sel only follows reads, so the output mux keeps showing the last word read.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ct        <= '0;
         wbank     <= 1'b0;
         rd_sel    <= 1'b0;
         VALID     <= 1'b0;
         FRAME_RDY <= 1'b0;
         OVF       <= 1'b0;
         BUSY      <= 1'b0;
         DOVAL     <= 1'b0;
      end else begin
         BUSY      <= (state_nx == FILL);
         FRAME_RDY <= last_write;
         OVF       <= last_write && VALID && !RD_DONE;
         DOVAL     <= RD_EN;
         if (START) begin
            ct <= '0;
         end else if (do_write) begin
            ct <= ct + (AW+1)'(1);
         end
         if (last_write) begin
            wbank <= ~wbank;
         end
         if (last_write) begin
            VALID <= 1'b1;
         end else if (RD_DONE) begin
            VALID <= 1'b0;
         end
         if (RD_EN) begin
            rd_sel <= ~wbank;
         end
      end
   end

`ifdef FRAME_RAM_BITREV_EN
   assign rd_addr = AW'(bitrev(32'(ADDR), AW));
`else
   assign rd_addr = ADDR;
`endif

   frame_ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
      .CLK   (CLK),
      .RST_N (RST_N),
      .we    (we0),
      .waddr (ct[AW-1:0]),
      .wdata ({DReal, DImag}),
      .re    (re0),
      .raddr (rd_addr),
      .rdata (rdata0)
   );

   frame_ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
      .CLK   (CLK),
      .RST_N (RST_N),
      .we    (we1),
      .waddr (ct[AW-1:0]),
      .wdata ({DReal, DImag}),
      .re    (re1),
      .raddr (rd_addr),
      .rdata (rdata1)
   );

   assign {DOReal, DOImag} = rd_sel ? rdata1 : rdata0;

endmodule

// File: tb/tb_frame_ram.sv
// Self-checking bench for frame_ram: read data is checked through a scoreboard queue,
// handshake outputs through direct comparisons. Honors FRAME_RAM_BITREV_EN.
module tb_frame_ram;

   localparam int W  = 32;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          CLK, RST_N, START, ED, RD_EN, RD_DONE;
   logic [W-1:0]  DReal, DImag, DOReal, DOImag;
   logic [AW-1:0] ADDR;
   logic          DOVAL, FRAME_RDY, VALID, OVF, BUSY;

   int n_tests = 0;
   int n_fail  = 0;
   int frdy_cnt = 0;
   int ovf_cnt  = 0;
   int rd_base  = 0;
   logic [63:0] sb [$];

   frame_ram #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .ED        (ED),
      .DReal     (DReal),
      .DImag     (DImag),
      .RD_EN     (RD_EN),
      .ADDR      (ADDR),
      .RD_DONE   (RD_DONE),
      .DOReal    (DOReal),
      .DOImag    (DOImag),
      .DOVAL     (DOVAL),
      .FRAME_RDY (FRAME_RDY),
      .VALID     (VALID),
      .OVF       (OVF),
      .BUSY      (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int phys(input int a);
      logic [3:0] x;
      x = 4'(a);
`ifdef FRAME_RAM_BITREV_EN
      return int'({x[0], x[1], x[2], x[3]});
`else
      return int'(x);
`endif
   endfunction

   function automatic logic [63:0] exp_word(input int base, input int a);
      int p;
      p = phys(a);
      return {32'(base + p), 32'(100 + base + p)};
   endfunction

   // Output monitor runs 1 time unit after each edge; the stimulus side works at +2.
   always @(posedge CLK) begin
      #1;
      if (RST_N) begin
         if (FRAME_RDY) frdy_cnt++;
         if (OVF) ovf_cnt++;
         if (DOVAL) begin
            if (sb.size() == 0) begin
               check("unexpected_doval", 64'(DOVAL), 64'(0));
            end else begin
               check("rd_data", {DOReal, DOImag}, sb.pop_front());
            end
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic send_frame(input int base, input bit rd_while, input bit done_start,
                             input bit done_last);
      int fr0;
      fr0 = frdy_cnt;
      START = 1'b1; RD_DONE = done_start;
      cyc();
      START = 1'b0; RD_DONE = 1'b0;
      check("busy_fill", 64'(BUSY), 64'(1));
      for (int i = 0; i < D; i++) begin
         ED = 1'b1; DReal = 32'(base + i); DImag = 32'(100 + base + i);
         if (rd_while) begin
            RD_EN = 1'b1; ADDR = 4'(i);
            sb.push_back(exp_word(rd_base, i));
         end
         RD_DONE = done_last && (i == D-1);
         cyc();
      end
      ED = 1'b0; RD_EN = 1'b0; RD_DONE = 1'b0;
      check("frame_rdy", 64'(FRAME_RDY), 64'(1));
      check("frame_rdy_once", 64'(frdy_cnt - fr0), 64'(1));
      check("busy_done", 64'(BUSY), 64'(0));
      rd_base = base;
   endtask

   task automatic read_frame();
      for (int a = 0; a < D; a++) begin
         RD_EN = 1'b1; ADDR = 4'(a);
         sb.push_back(exp_word(rd_base, a));
         cyc();
      end
      RD_EN = 1'b0;
      cyc();
   endtask

   initial begin
      int fr0, ov0;
      RST_N = 1'b0; START = 1'b0; ED = 1'b0; RD_EN = 1'b0; RD_DONE = 1'b0;
      DReal = '0; DImag = '0; ADDR = '0;
      repeat (2) @(posedge CLK);
      #2;
      check("rst_doreal", 64'(DOReal), 64'(0));
      check("rst_doimag", 64'(DOImag), 64'(0));
      check("rst_flags", 64'({DOVAL, FRAME_RDY, VALID, OVF, BUSY}), 64'(0));
      @(negedge CLK);
      RST_N = 1'b1;
      cyc();

      // Single frame capture and readback.
      send_frame(0, 1'b0, 1'b0, 1'b0);
      check("valid_after_a", 64'(VALID), 64'(1));
      cyc();
      check("frame_rdy_low", 64'(FRAME_RDY), 64'(0));
      read_frame();

      // Ping-pong: release A with START of B, read A during B's capture.
      send_frame(16, 1'b1, 1'b1, 1'b0);
      check("pp_ovf", 64'(OVF), 64'(0));
      check("pp_valid", 64'(VALID), 64'(1));
      read_frame();
      RD_DONE = 1'b1;
      cyc();
      RD_DONE = 1'b0;
      check("rd_done_clears", 64'(VALID), 64'(0));

      // Overflow: two frames without release.
      ov0 = ovf_cnt;
      send_frame(32, 1'b0, 1'b0, 1'b0);
      check("ovf_first", 64'(OVF), 64'(0));
      send_frame(48, 1'b0, 1'b0, 1'b0);
      check("ovf_second", 64'(OVF), 64'(1));
      check("ovf_count", 64'(ovf_cnt - ov0), 64'(1));
      cyc();
      check("ovf_pulse_end", 64'(OVF), 64'(0));
      read_frame();
      // RD_DONE coinciding with the swap suppresses OVF and keeps VALID.
      ov0 = ovf_cnt;
      send_frame(64, 1'b0, 1'b0, 1'b1);
      check("swap_done_ovf", 64'(OVF), 64'(0));
      check("swap_done_valid", 64'(VALID), 64'(1));
      check("swap_done_cnt", 64'(ovf_cnt - ov0), 64'(0));
      read_frame();

      // Restart: partial frame, START+ED collision, then a full frame.
      fr0 = frdy_cnt;
      START = 1'b1;
      cyc();
      START = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ED = 1'b1; DReal = 32'(200 + i); DImag = 32'(300 + i);
         cyc();
      end
      START = 1'b1; ED = 1'b1; DReal = 32'd999; DImag = 32'd999;
      cyc();
      START = 1'b0;
      for (int i = 0; i < D; i++) begin
         ED = 1'b1; DReal = 32'(300 + i); DImag = 32'(400 + i);
         cyc();
         if (i == D-2) check("restart_no_early_rdy", 64'(frdy_cnt - fr0), 64'(0));
      end
      ED = 1'b0;
      check("restart_single_rdy", 64'(frdy_cnt - fr0), 64'(1));
      rd_base = 300;
      read_frame();

      // Async reset mid-frame, between edges, with reads in flight.
      START = 1'b1;
      cyc();
      START = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ED = 1'b1; DReal = 32'(600 + i); DImag = 32'(700 + i);
         RD_EN = 1'b1; ADDR = 4'(i + 3);
         sb.push_back(exp_word(rd_base, i + 3));
         cyc();
      end
      #2;
      RST_N = 1'b0;
      ED = 1'b0; RD_EN = 1'b0;
      #1;
      check("arst_doreal", 64'(DOReal), 64'(0));
      check("arst_doimag", 64'(DOImag), 64'(0));
      check("arst_flags", 64'({DOVAL, FRAME_RDY, VALID, OVF, BUSY}), 64'(0));
      sb.delete();
      #2;
      RST_N = 1'b1;
      fr0 = frdy_cnt;
      for (int i = 0; i < 20; i++) begin
         ED = 1'b1; DReal = 32'(i); DImag = 32'(i);
         cyc();
      end
      ED = 1'b0;
      check("post_rst_no_rdy", 64'(frdy_cnt - fr0), 64'(0));
      check("post_rst_idle", 64'({VALID, BUSY}), 64'(0));

      // Normal operation resumes once START is given.
      send_frame(500, 1'b0, 1'b0, 1'b0);
      read_frame();

      cyc();
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
